// File: rtl/if_pkg.sv
// Shared definitions for the instruction-fetch prefetch stage.
//   XLEN_DEF     : default PC / instruction width
//   RESET_PC_DEF : default PC loaded while reset is asserted
//   PC_STEP_DEF  : default byte distance between sequential fetches
//   NOP_INSTR    : canonical no-op encoding (addi x0, x0, 0), used as bubble content
package if_pkg;

    localparam int          XLEN_DEF     = 32;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam int          PC_STEP_DEF  = 4;
    localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO holding fetched {pc, instr} pairs.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   i_push, i_wdata : write one entry (ignored when full)
//   i_pop           : drop the head entry (ignored when empty)
//   i_flush         : empty the FIFO at the clock edge; wins over push/pop
//   o_rdata         : head entry
//   o_full, o_empty : occupancy flags
//   o_count         : number of valid entries, 0..DEPTH
module fetch_fifo #(
    parameter int               WIDTH   = 64,
    parameter int               DEPTH   = 4,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_wdata,
    input  logic                       i_pop,
    input  logic                       i_flush,
    output logic [WIDTH-1:0]           o_rdata,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_rdata   = r_mem[r_rd_ptr];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= RST_VAL;
            end
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_wdata;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/if_prefetch_stage.sv
// Instruction-fetch prefetch stage: issues sequential fetches to a fixed
// one-cycle-latency instruction memory and buffers the returned words, each
// tagged with its fetch address, in a small FIFO toward decode.
// Ports:
//   clk, rst_n                  : clock, asynchronous active-low reset
//   redirect_valid, redirect_pc : taken jump/branch; reload PC and flush
//   imem_req, imem_addr         : fetch request and address (current PC)
//   imem_rdata                  : returned word, one cycle after imem_req
//   out_valid, out_ready        : handshake toward decode
//   out_instr, out_pc           : head instruction and its address
module if_prefetch_stage
    import if_pkg::*;
#(
    parameter int              XLEN     = XLEN_DEF,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF),
    parameter int              PC_STEP  = PC_STEP_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_instr,
    output logic [XLEN-1:0] out_pc
);

    localparam int              CW      = $clog2(DEPTH) + 1;
    localparam int              FW      = 2 * XLEN;
    localparam logic [CW:0]     L_DEPTH = (CW + 1)'(DEPTH);
    localparam logic [FW-1:0]   L_BUBBLE = {{XLEN{1'b0}}, XLEN'(NOP_INSTR)};

    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_req_pc;
    logic            r_inflight;

    logic            w_push;
    logic            w_pop;
    logic            w_full;
    logic            w_empty;
    logic [CW-1:0]   w_count;
    logic [CW:0]     w_occ;
    logic [FW-1:0]   w_head;
    logic [XLEN-1:0] w_redirect_pc;

    assign w_redirect_pc = {redirect_pc[XLEN-1:2], 2'b00};

    // Credit counts stored entries plus the word still in flight; a pop
    // happening this cycle is deliberately not counted as free space.
    assign w_occ    = {1'b0, w_count} + {{CW{1'b0}}, r_inflight};
    assign imem_req = rst_n && !redirect_valid && (w_occ < L_DEPTH);
    assign imem_addr = r_pc;

    // A response landing in a redirect cycle belongs to the old stream and
    // is dropped; the flush empties whatever is already buffered.
    assign w_push = r_inflight && !redirect_valid && !w_full;
    assign w_pop  = !w_empty && out_ready;

    assign out_valid = !w_empty;
    assign out_instr = w_empty ? '0 : w_head[XLEN-1:0];
    assign out_pc    = w_empty ? '0 : w_head[FW-1:XLEN];

    // Reset clears r_inflight, so a word requested before reset is never pushed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc       <= RESET_PC;
            r_req_pc   <= '0;
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= imem_req;
            if (imem_req) begin
                r_req_pc <= r_pc;
            end
            if (redirect_valid) begin
                r_pc <= w_redirect_pc;
            end else if (imem_req) begin
                r_pc <= r_pc + XLEN'(PC_STEP);
            end
        end
    end

    fetch_fifo #(
        .WIDTH   (FW),
        .DEPTH   (DEPTH),
        .RST_VAL (L_BUBBLE)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_wdata ({r_req_pc, imem_rdata}),
        .i_pop   (w_pop),
        .i_flush (redirect_valid),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

endmodule

// File: tb/tb_if_prefetch_stage.sv
module tb_if_prefetch_stage;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;

    int checks   = 0;
    int failures = 0;

    // Reference model: queue of delivered {pc, instr}, PC, one in-flight slot.
    logic [63:0] m_q[$];
    logic [31:0] m_pc;
    logic        m_infl;
    logic [31:0] m_ipc;

    // Memory model and last sampled request.
    logic        mem_pend;
    logic [31:0] mem_word;
    logic        s_req;
    logic [31:0] s_addr;
    int          n_req;

    always #5 clk = ~clk;

    if_prefetch_stage #(
        .XLEN     (32),
        .DEPTH    (DEPTH),
        .RESET_PC (32'h0000_0000),
        .PC_STEP  (4)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_pc     = 32'h0;
        m_infl   = 1'b0;
        m_ipc    = 32'h0;
        mem_pend = 1'b0;
    endtask

    // One clock cycle; entered and left at a falling edge.
    task automatic step(input logic rv, input logic [31:0] rpc, input logic rdy);
        logic m_req;
        logic pop;
        redirect_valid = rv;
        redirect_pc    = rpc;
        out_ready      = rdy;
        imem_rdata     = mem_pend ? mem_word : $urandom();
        #1;
        m_req = !rv && ((m_q.size() + (m_infl ? 1 : 0)) < DEPTH);
        chk("imem_req", {31'b0, imem_req}, {31'b0, m_req});
        chk("imem_addr", imem_addr, m_pc);
        chk("out_valid", {31'b0, out_valid}, {31'b0, (m_q.size() != 0)});
        if (m_q.size() != 0) begin
            chk("out_pc", out_pc, m_q[0][63:32]);
            chk("out_instr", out_instr, m_q[0][31:0]);
        end
        s_req    = imem_req;
        s_addr   = imem_addr;
        mem_pend = imem_req;
        mem_word = imem_addr + 32'd1000;
        pop = (m_q.size() != 0) && rdy;
        if (pop) void'(m_q.pop_front());
        if (rv) m_q.delete();
        else if (m_infl) m_q.push_back({m_ipc, m_ipc + 32'd1000});
        m_infl = m_req;
        m_ipc  = m_pc;
        if (rv) m_pc = {rpc[31:2], 2'b00};
        else if (m_req) m_pc = m_pc + 32'd4;
        @(negedge clk);
    endtask

    // One-cycle reset pulse; the memory still returns the pending word.
    task automatic pulse_reset();
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        out_ready      = 1'b1;
        imem_rdata     = mem_pend ? mem_word : $urandom();
        #1;
        chk("rst_imem_req", {31'b0, imem_req}, 32'h0);
        chk("rst_imem_addr", imem_addr, 32'h0);
        chk("rst_out_valid", {31'b0, out_valid}, 32'h0);
        chk("rst_out_pc", out_pc, 32'h0);
        chk("rst_out_instr", out_instr, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        out_ready      = 1'b1;
        imem_rdata     = 32'h0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("por_imem_req", {31'b0, imem_req}, 32'h0);
        chk("por_out_valid", {31'b0, out_valid}, 32'h0);
        chk("por_out_pc", out_pc, 32'h0);
        chk("por_out_instr", out_instr, 32'h0);
        rst_n = 1'b1;

        // Streaming from reset with decode always ready.
        for (int i = 0; i < 10; i++) step(1'b0, 32'h0, 1'b1);

        // Reset mid-stream with a request in flight, then stall decode.
        pulse_reset();
        n_req = 0;
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 32'h0, 1'b0);
            n_req += s_req ? 1 : 0;
        end
        chk("stall_req_count", n_req, 32'd4);
        for (int i = 0; i < 10; i++) step(1'b0, 32'h0, 1'b1);

        // Redirect with 3 buffered entries and one in flight.
        pulse_reset();
        for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b0);
        step(1'b1, 32'h100, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b0, 32'h0, 1'b1);

        // Misaligned redirect target.
        step(1'b1, 32'h203, 1'b1);
        step(1'b0, 32'h0, 1'b1);
        chk("align_addr", s_addr, 32'h200);
        for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b1);

        // Back-to-back redirects.
        step(1'b1, 32'h40, 1'b1);
        step(1'b1, 32'h80, 1'b1);
        step(1'b0, 32'h0, 1'b1);
        chk("b2b_addr", s_addr, 32'h80);
        for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b1);

        // Randomized traffic, including PC wrap region and reset pulses.
        step(1'b1, 32'hFFFF_FFF0, 1'b1);
        for (int i = 0; i < 400; i++) begin
            if (i == 200) pulse_reset();
            step(($urandom_range(0, 7) == 0), $urandom(), ($urandom_range(0, 3) != 0));
        end
        for (int i = 0; i < 8; i++) step(1'b0, 32'h0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
